// File: rtl/cpu_pkg.sv
// cpu_pkg: shared pipeline types for the memory/writeback stage.
package cpu_pkg;
  localparam int TIMEOUT_DEF = 16;
  localparam int ADDR_ALIGN_DEF = 3;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  aw;
    logic        regwrite;
    logic        rd_x30;
    logic [63:0] pcplus4;
  } wb_t;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts cycles spent waiting on memory; expired on the last allowed cycle.
module mem_wait_timer #(parameter int TIMEOUT = 16) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  assign o_expired = r_cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + CW'(1);
endmodule

// File: rtl/register.sv
// register: generic pipeline register with asynchronous active-high reset.
module register #(parameter int W = 1) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else q <= d;
endmodule

// File: rtl/mem_wb_staged.sv
// mem_wb_staged: LDUR/STUR via req/ack data memory, then registered writeback bundle.
module mem_wb_staged
  import cpu_pkg::*;
#(
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter int ADDR_ALIGN = ADDR_ALIGN_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [63:0] ALU_in,
  input  logic [63:0] Db_in,
  input  logic [4:0]  Aw_in,
  input  logic [63:0] PCPlusFour_in,
  input  logic        MemToReg_in,
  input  logic        MemWrite_in,
  input  logic        RegWrite_in,
  input  logic        Rd_X30_in,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ack,
  output logic [63:0] MemStage_out,
  output logic [4:0]  Aw_out,
  output logic        RegWrite_out,
  output logic        Rd_X30_out,
  output logic [63:0] PCPlusFour_out,
  output logic        mem_err
);
  state_t      r_state;
  logic        r_req, r_we, r_memtoreg, r_regwrite, r_rd_x30, r_err;
  logic [63:0] r_addr, r_wdata, r_pc4;
  logic [4:0]  r_aw;
  wb_t         w_wb_d, w_wb_q;
  logic        w_busy, w_accept, w_memop, w_mis, w_issue, w_ack, w_expired, w_abort;
  assign w_busy   = r_state == BUSY;
  assign w_accept = valid_in & ~w_busy;
  assign w_memop  = MemToReg_in | MemWrite_in;
  assign w_mis    = |ALU_in[ADDR_ALIGN-1:0];
  assign w_issue  = w_accept & w_memop & ~w_mis;
  assign w_ack    = w_busy & mem_ack;
  assign w_abort  = w_busy & ~mem_ack & w_expired;
  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk), .rst(reset), .i_clr(w_issue), .i_en(w_busy), .o_expired(w_expired)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state    <= IDLE;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_memtoreg <= 1'b0;
      r_regwrite <= 1'b0;
      r_rd_x30   <= 1'b0;
      r_aw       <= '0;
      r_pc4      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= r_err | (w_accept & w_memop & w_mis) | w_abort;
      if (w_issue) begin
        r_state    <= BUSY;
        r_req      <= 1'b1;
        r_we       <= MemWrite_in;
        r_addr     <= ALU_in;
        r_wdata    <= Db_in;
        r_memtoreg <= MemToReg_in;
        r_regwrite <= RegWrite_in;
        r_rd_x30   <= Rd_X30_in;
        r_aw       <= Aw_in;
        r_pc4      <= PCPlusFour_in;
      end else if (w_ack | w_abort) begin
        r_state <= IDLE;
        r_req   <= 1'b0;
      end
    end
  // Memory ops never write back on the accept slot; only the ack completes them.
  always_comb begin
    w_wb_d = w_wb_q;
    w_wb_d.regwrite = 1'b0;
    if (w_accept) w_wb_d = '{ALU_in, Aw_in, RegWrite_in & ~w_memop, Rd_X30_in, PCPlusFour_in};
    else if (w_ack) w_wb_d = '{r_memtoreg ? mem_rdata : r_addr, r_aw, r_regwrite, r_rd_x30, r_pc4};
  end
  register #(.W($bits(wb_t))) u_wb_reg (.clk(clk), .rst(reset), .d(w_wb_d), .q(w_wb_q));
  assign stall          = w_busy;
  assign mem_req        = r_req;
  assign mem_we         = r_we;
  assign mem_addr       = r_addr;
  assign mem_wdata      = r_wdata;
  assign mem_err        = r_err;
  assign MemStage_out   = w_wb_q.data;
  assign Aw_out         = w_wb_q.aw;
  assign RegWrite_out   = w_wb_q.regwrite;
  assign Rd_X30_out     = w_wb_q.rd_x30;
  assign PCPlusFour_out = w_wb_q.pcplus4;
endmodule

// File: doc/mem_wb_staged.md
Name: mem_wb_staged

Overview:
Memory-access and writeback stage of the pipelined ARM core.
- Accepts the ALU-stage result and control bundle.
- Performs LDUR/STUR through a req/ack data-memory handshake, stalling upstream while a transfer is outstanding.
- Registers the writeback bundle that feeds the decode stage's register-file write port and forwarding inputs: MemStage, Aw, RegWrite, Rd_X30, PCPlusFour.

Parameters:
TIMEOUT, 16, maximum cycles spent in BUSY waiting for mem_ack before the access is aborted
ADDR_ALIGN, 3, number of low address bits that must be zero for a legal 64-bit access

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous, active-high reset
valid_in  in  1  upstream bundle is valid this cycle
ALU_in  in  64  ALU result; used as the memory address for memory ops
Db_in  in  64  store data
Aw_in  in  5  destination register
PCPlusFour_in  in  64  PC+4, used for BL writeback
MemToReg_in  in  1  load
MemWrite_in  in  1  store
RegWrite_in  in  1  destination register write enable
Rd_X30_in  in  1  write PC+4 to X30
stall  out  1  upstream must hold its bundle; combinational
mem_req  out  1  data memory request; registered
mem_we  out  1  1 = write, 0 = read
mem_addr  out  64  access address
mem_wdata  out  64  store data
mem_rdata  in  64  load data; valid when mem_ack=1
mem_ack  in  1  single-cycle completion pulse
MemStage_out  out  64  writeback data (load data or ALU result)
Aw_out  out  5  writeback register
RegWrite_out  out  1  writeback enable
Rd_X30_out  out  1  writeback source select
PCPlusFour_out  out  64  PC+4 for writeback
mem_err  out  1  sticky error flag: misaligned access or timeout

Behaviour:
Clocking and reset (already decided):
- One clock, clk. reset is asynchronous and active-high.
- On reset, all outputs and state go to 0 immediately, FSM goes to IDLE, and mem_req drops immediately. Any pending access is discarded.

Definitions:
- accept = valid_in & ~stall
- memop = MemToReg_in | MemWrite_in
- misaligned = |ALU_in[ADDR_ALIGN-1:0]

FSM states: IDLE, BUSY. stall = (state==BUSY).

IDLE, on accept with ~memop:
- WB registers load at the next edge: MemStage_out=ALU_in; Aw, RegWrite, Rd_X30, PCPlusFour copied from inputs.
- Latency is 1 edge.

IDLE, on accept with memop & misaligned:
- No request is issued.
- mem_err is set.
- WB registers load with RegWrite_out=0 (bubble).

IDLE, on accept with memop & aligned:
- At that edge, latch mem_addr=ALU_in, mem_wdata=Db_in, mem_we=MemWrite_in, and the control bundle.
- Set mem_req=1, clear wait_cnt, go to BUSY.
- RegWrite_out=0 for this cycle's WB slot.

BUSY:
- mem_req, mem_addr, mem_wdata and mem_we hold stable.
- valid_in and upstream inputs are ignored.
- wait_cnt increments every cycle.
- mem_ack=1 at an edge: WB registers load (MemStage_out = latched MemToReg ? mem_rdata : latched address); RegWrite_out = latched RegWrite; mem_req goes to 0; go to IDLE.
- No ack and wait_cnt==TIMEOUT-1: abort. mem_err is set, mem_req goes to 0, WB slot is a bubble (RegWrite_out=0), go to IDLE.
- Ack and timeout in the same cycle: ack wins.

Load latency: ack in the first BUSY cycle gives WB valid 2 edges after accept. In general, WB is valid k+1 edges after accept when ack arrives in BUSY cycle k.

Other rules:
- mem_ack while IDLE is ignored.
- Any cycle with no completion (no accept, or BUSY without ack) loads RegWrite_out=0. Other WB fields may hold.
- A store writes no register unless RegWrite_in was set.
- mem_err clears only on reset.

Decomposition:
- Shared package cpu_pkg holds the state enum typedef (IDLE, BUSY) and the WB bundle struct (data 64, aw 5, regwrite, rd_x30, pcplus4 64).
- Reuse the existing register module for the WB pipeline registers.
- One sub-module, mem_wait_timer: a counter with clear, enable and expired outputs, parameterised by TIMEOUT.

Test Plan:
- ALU op (ALU_in=16, Aw_in=3, RegWrite=1, valid) -> next edge: MemStage_out=16, Aw_out=3, RegWrite_out=1, stall never asserted.
- LDUR addr 0x20 with mem_ack 2 cycles after mem_req rises, mem_rdata=0xBEEF -> stall high for 2 cycles, mem_addr=0x20, mem_we=0; after the ack edge MemStage_out=0xBEEF, RegWrite_out=1; mem_req low.
- STUR addr 0x08, Db_in=99, ack in the first BUSY cycle -> mem_we=1, mem_wdata=99; RegWrite_out stays 0; stall exactly 1 cycle.
- Misaligned LDUR addr 0x0C -> mem_req never asserted, mem_err=1, RegWrite_out=0, stall stays 0.
- Load with no ack, TIMEOUT=16 -> mem_req high exactly 16 cycles then drops, mem_err=1, RegWrite_out=0; the next ALU op completes normally.
- reset asserted mid-BUSY -> mem_req, stall, RegWrite_out and mem_err go to 0 without waiting for a clock edge; a late mem_ack after reset is ignored.
